// File: rtl/riscv_instr_aligner.sv
// Instruction aligner between the prefetch buffer and the compressed decoder.
// Extracts one 16- or 32-bit instruction per handshake from word-aligned fetch data.
module riscv_instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        is_compressed_o
);

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        MIS32   = 2'd1,
        MIS16   = 2'd2,
        BR_MIS  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] resid_q, resid_d;
    logic [31:0] pc_q, pc_d;
    logic        transfer;
    state_t      upper_state;

    always_comb begin
        state_d         = state_q;
        resid_d         = resid_q;
        pc_d            = pc_q;
        instr_valid_o   = 1'b0;
        fetch_ready_o   = 1'b0;
        instr_o         = '0;
        is_compressed_o = 1'b0;
        transfer        = 1'b0;
        // The upper halfword of the current word decides what the next state must wait for.
        upper_state     = (fetch_rdata_i[17:16] == 2'b11) ? MIS32 : MIS16;

        unique case (state_q)
            ALIGNED: begin
                instr_valid_o = fetch_valid_i;
                fetch_ready_o = fetch_valid_i && instr_ready_i;
                if (fetch_rdata_i[1:0] == 2'b11) instr_o = fetch_rdata_i;
                else                              instr_o = {16'h0000, fetch_rdata_i[15:0]};
            end
            MIS32: begin
                instr_valid_o = fetch_valid_i;
                fetch_ready_o = fetch_valid_i && instr_ready_i;
                instr_o       = {fetch_rdata_i[15:0], resid_q};
            end
            MIS16: begin
                instr_valid_o = 1'b1;
                instr_o       = {16'h0000, resid_q};
            end
            BR_MIS: begin
                fetch_ready_o = fetch_valid_i;
            end
        endcase

        is_compressed_o = (instr_o[1:0] != 2'b11);

        if (branch_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
            pc_d          = {branch_addr_i[31:1], 1'b0};
            resid_d       = '0;
            state_d       = branch_addr_i[1] ? BR_MIS : ALIGNED;
        end else begin
            transfer = instr_valid_o && instr_ready_i;
            if (transfer) pc_d = pc_q + (is_compressed_o ? 32'd2 : 32'd4);
            unique case (state_q)
                ALIGNED: begin
                    if (transfer && is_compressed_o) begin
                        resid_d = fetch_rdata_i[31:16];
                        state_d = upper_state;
                    end
                end
                MIS32: begin
                    if (transfer) begin
                        resid_d = fetch_rdata_i[31:16];
                        state_d = upper_state;
                    end
                end
                MIS16: begin
                    if (transfer) state_d = ALIGNED;
                end
                BR_MIS: begin
                    if (fetch_valid_i) begin
                        resid_d = fetch_rdata_i[31:16];
                        state_d = upper_state;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            resid_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            resid_q <= resid_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Bench for riscv_instr_aligner: halfword-stream reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_riscv_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        is_compressed_o;

    int checks = 0;
    int errors = 0;

    riscv_instr_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .branch_i        (branch_i),
        .branch_addr_i   (branch_addr_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_rdata_i   (fetch_rdata_i),
        .fetch_ready_o   (fetch_ready_o),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .is_compressed_o (is_compressed_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending halfwords, a pending-skip flag and a PC.
    logic [15:0] hq[$];
    logic        skip;
    logic [31:0] mpc;

    initial begin
        logic        e_valid, e_ready, e_comp, e_tr, e_pop;
        logic [31:0] e_instr;
        int          len;
        logic [15:0] s[$];
        hq.delete(); skip = 1'b0; mpc = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hq.delete(); skip = 1'b0; mpc = 32'h0;
            end
            e_valid = 1'b0; e_ready = 1'b0; e_comp = 1'b0; e_instr = '0;
            e_tr = 1'b0; e_pop = 1'b0; len = 0;
            if (branch_i) begin
                // nothing leaves or enters on a redirect cycle
            end else if (skip) begin
                e_ready = fetch_valid_i;
                e_pop   = fetch_valid_i;
            end else begin
                s = hq;
                if (fetch_valid_i) begin
                    s.push_back(fetch_rdata_i[15:0]);
                    s.push_back(fetch_rdata_i[31:16]);
                end
                if (s.size() >= 1 && s[0][1:0] != 2'b11) len = 1;
                else if (s.size() >= 2)                 len = 2;
                if (len > 0) begin
                    e_valid = 1'b1;
                    e_comp  = (len == 1);
                    e_instr = (len == 1) ? {16'h0000, s[0]} : {s[1], s[0]};
                end
                e_tr    = e_valid && instr_ready_i;
                e_pop   = e_tr && (len > hq.size());
                e_ready = e_pop;
            end
            chk("model_valid", {31'h0, instr_valid_o}, {31'h0, e_valid});
            chk("model_fetch_ready", {31'h0, fetch_ready_o}, {31'h0, e_ready});
            chk("model_pc", pc_o, mpc);
            if (e_valid) begin
                chk("model_instr", instr_o, e_instr);
                chk("model_compressed", {31'h0, is_compressed_o}, {31'h0, e_comp});
            end
            @(posedge clk);
            if (!rst_n) begin
                hq.delete(); skip = 1'b0; mpc = 32'h0;
            end else if (branch_i) begin
                hq.delete();
                mpc  = {branch_addr_i[31:1], 1'b0};
                skip = branch_addr_i[1];
            end else if (skip) begin
                if (e_pop) begin
                    hq.push_back(fetch_rdata_i[31:16]);
                    skip = 1'b0;
                end
            end else if (e_tr) begin
                if (e_pop) begin
                    hq.push_back(fetch_rdata_i[15:0]);
                    hq.push_back(fetch_rdata_i[31:16]);
                end
                for (int unsigned k = 0; k < len; k++) void'(hq.pop_front());
                mpc = mpc + 32'(2 * len);
            end
        end
    end

    // Inputs change just after the rising edge; the task returns at the following falling edge.
    task automatic drive(input logic rst, input logic br, input logic [31:0] ba,
                         input logic fv, input logic [31:0] fd, input logic rdy);
        @(posedge clk); #1;
        rst_n = rst; branch_i = br; branch_addr_i = ba;
        fetch_valid_i = fv; fetch_rdata_i = fd; instr_ready_i = rdy;
        @(negedge clk);
    endtask

    logic [31:0] words [8] = '{32'h4505_0505, 32'h0093_0505, 32'h0001_0010, 32'h0000_0013,
                               32'h00A3_8001, 32'h1234_0413, 32'h8082_0001, 32'hFFFF_FFFF};

    initial begin
        rst_n = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
        fetch_valid_i = 1'b0; fetch_rdata_i = '0; instr_ready_i = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        chk("reset_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("reset_fetch_ready", {31'h0, fetch_ready_o}, 32'h0);
        chk("reset_pc", pc_o, 32'h0);

        drive(1, 0, 0, 1, 32'h0000_0013, 1);
        chk("a32_instr", instr_o, 32'h0000_0013);
        chk("a32_pc", pc_o, 32'h0);
        chk("a32_comp", {31'h0, is_compressed_o}, 32'h0);
        chk("a32_pop", {31'h0, fetch_ready_o}, 32'h1);

        drive(1, 0, 0, 1, 32'h4505_0505, 1);
        chk("c1_instr", instr_o, 32'h0000_0505);
        chk("c1_pc", pc_o, 32'h4);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("c2_instr", instr_o, 32'h0000_4505);
        chk("c2_pc", pc_o, 32'h6);
        chk("c2_no_pop", {31'h0, fetch_ready_o}, 32'h0);

        drive(1, 0, 0, 1, 32'h0093_0505, 1);
        chk("st_c_instr", instr_o, 32'h0000_0505);
        chk("st_c_pc", pc_o, 32'h8);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("st_wait_valid", {31'h0, instr_valid_o}, 32'h0);
        drive(1, 0, 0, 1, 32'h0001_0010, 1);
        chk("st_32_instr", instr_o, 32'h0010_0093);
        chk("st_32_pc", pc_o, 32'hA);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("st_resid_instr", instr_o, 32'h0000_0001);
        chk("st_resid_pc", pc_o, 32'hE);

        drive(1, 1, 32'h0000_0103, 0, 32'h0, 1);
        chk("br_valid", {31'h0, instr_valid_o}, 32'h0);
        drive(1, 0, 0, 1, 32'h0505_1234, 1);
        chk("brmis_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("brmis_pop", {31'h0, fetch_ready_o}, 32'h1);
        drive(1, 0, 0, 0, 32'h0, 1);
        chk("brmis_instr", instr_o, 32'h0000_0505);
        chk("brmis_pc", pc_o, 32'h102);

        drive(1, 0, 0, 1, 32'h0093_0505, 1);
        for (int unsigned i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1, 32'h0001_0010, 0);
            chk("bp_instr", instr_o, 32'h0010_0093);
            chk("bp_pc", pc_o, 32'h106);
            chk("bp_no_pop", {31'h0, fetch_ready_o}, 32'h0);
        end
        drive(1, 0, 0, 1, 32'h0001_0010, 1);
        chk("bp_release_pop", {31'h0, fetch_ready_o}, 32'h1);
        drive(1, 0, 0, 0, 32'h0, 0);
        chk("bp_after_pc", pc_o, 32'h10A);

        drive(1, 1, 32'h0000_0200, 0, 32'h0, 1);
        chk("br16_valid", {31'h0, instr_valid_o}, 32'h0);
        chk("br16_no_pop", {31'h0, fetch_ready_o}, 32'h0);
        drive(1, 0, 0, 1, 32'h0000_0013, 1);
        chk("br16_target_pc", pc_o, 32'h200);

        drive(1, 0, 0, 1, 32'h0093_0505, 1);
        drive(0, 0, 0, 0, 32'h0, 1);
        chk("rst_mid_pc", pc_o, 32'h0);
        chk("rst_mid_valid", {31'h0, instr_valid_o}, 32'h0);
        drive(1, 0, 0, 1, 32'h0000_0013, 1);
        chk("rst_clean_instr", instr_o, 32'h0000_0013);

        drive(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
        drive(1, 0, 0, 1, 32'h0000_0013, 1);
        chk("wrap_pre_pc", pc_o, 32'hFFFF_FFFC);
        drive(1, 0, 0, 1, 32'h4505_0505, 1);
        chk("wrap_pc", pc_o, 32'h0);

        // Mixed stream with stalls and gaps, checked by the model only.
        for (int unsigned i = 0; i < 40; i++) begin
            drive(1, (i == 23), 32'h0000_0302, (i % 5) != 3, words[i % 8], (i % 3) != 1);
        end
        drive(1, 0, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 0, 32'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_instr_aligner.md
Name: riscv_instr_aligner

Overview:
- Sits between the prefetch buffer and the compressed decoder in the IF stage.
- Takes 32-bit word-aligned fetch words and extracts one instruction per handshake: 16-bit compressed or 32-bit, including 32-bit instructions that straddle two words.
- Tracks the PC of each emitted instruction and handles branches to halfword-aligned targets.
- Its instr_o feeds the decoder's instr_i directly.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- branch_i  in  1  redirect request, single-cycle pulse
- branch_addr_i  in  32  redirect target; bit 0 is ignored
- fetch_valid_i  in  1  fetch word available
- fetch_rdata_i  in  32  fetch word, always from a word-aligned address
- fetch_ready_o  out  1  fetch word consumed this cycle when high with fetch_valid_i
- instr_valid_o  out  1  instr_o/pc_o valid
- instr_ready_i  in  1  decoder accepts the instruction
- instr_o  out  32  aligned instruction; compressed instructions are zero-extended in [31:16]
- pc_o  out  32  address of instr_o
- is_compressed_o  out  1  instr_o[1:0] != 2'b11

Behaviour:
- Registers:
  - state_q, one of ALIGNED, MIS32, MIS16, BR_MIS
  - resid_q [15:0], the held upper halfword
  - pc_q [31:0]
- Reset values: state_q=ALIGNED, resid_q=0, pc_q=RESET_PC.
- All outputs are combinational from the registers and inputs. Consequence of reset: instr_valid_o=0 and fetch_ready_o=0 while fetch_valid_i=0; pc_o=RESET_PC.
- Transfer and pop rules:
  - Instruction transfer happens when instr_valid_o && instr_ready_i.
  - Fetch pop happens when fetch_valid_i && fetch_ready_o.
  - Every transfer advances pc_q by 2 (compressed) or 4.
- ALIGNED, word W:
  - instr_valid_o = fetch_valid_i.
  - If W[1:0]==11: instr_o=W. On transfer, pop W and stay ALIGNED.
  - Else: instr_o={16'h0, W[15:0]}. On transfer, pop W and set resid_q=W[31:16]. Next state is MIS16 if W[17:16]!=11, else MIS32.
- MIS16:
  - instr_valid_o=1, instr_o={16'h0, resid_q}, fetch_ready_o=0; fetch_valid_i is not required.
  - On transfer, go to ALIGNED.
- MIS32, next word W:
  - instr_valid_o = fetch_valid_i, instr_o={W[15:0], resid_q}.
  - On transfer, pop W and set resid_q=W[31:16]. Next state is MIS16 if W[17:16]!=11, else MIS32.
- BR_MIS, word W:
  - instr_valid_o=0 and fetch_ready_o=fetch_valid_i; the lower half of W is discarded.
  - On pop, set resid_q=W[31:16]. Next state is MIS16 or MIS32 by W[17:16], as above.
  - pc_q is unchanged and already equals the target.
- pc_o = pc_q in every state.
- branch_i has priority over everything else in its cycle:
  - instr_valid_o=0 and fetch_ready_o=0; no transfer and no pop.
  - Next cycle: pc_q={branch_addr_i[31:1], 1'b0}; resid_q is discarded.
  - Next state is ALIGNED if branch_addr_i[1]==0, else BR_MIS.
  - The prefetch buffer flushes itself on the same branch_i; words arriving afterwards are from the target word address.
- Backpressure: when instr_ready_i=0, no pop and no register change; instr_o/pc_o stay stable as long as fetch_rdata_i is stable.
- Invariant: fetch_ready_o is never high in MIS16 or during a branch.
- pc_q wraps modulo 2^32.
- Reset mid-operation returns to reset values immediately (asynchronous); no residue survives.
- No illegal-instruction checking here; that belongs to the decoder.

Test Plan:
- Reset, fetch 32'h0000_0013 with ready=1 -> instr_o=32'h0000_0013, pc_o=RESET_PC, is_compressed_o=0, popped; pc becomes RESET_PC+4.
- Fetch 32'h4505_0505 (two compressed: c.addi 0x0505, c.li 0x4505) -> first cycle instr_o=32'h0000_0505, pc=0; second cycle instr_o=32'h0000_4505, pc=2, fetch_ready_o=0; then ALIGNED, pc=4.
- Straddling: words 32'h0093_0505, 32'h0001_0010 -> c-instr at pc 0; then 32-bit 32'h0010_0093 at pc 2, emitted only once the second word is valid; then MIS16 with residue 16'h0001 at pc 6.
- Branch to 32'h0000_0102, then word 32'h0505_1234 -> that word is popped with no output; next instr_o=32'h0000_0505 at pc 0x102.
- Hold instr_ready_i=0 for 5 cycles in MIS32 -> outputs stable, no pop, pc unchanged; release -> single transfer.
- Assert branch_i while instr_valid_o would be high in MIS16, and assert rst_n low mid-MIS32 -> no transfer or pop on the branch cycle; after reset, state ALIGNED and pc=RESET_PC.
